// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard controller bus between pipeline and pipe_ctrl
interface pipe_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int NUM_STAGES = 5
);
    logic [NUM_STAGES-1:0] stallreq_i;
    logic                  branch_flag_i;
    logic [ADDR_W-1:0]     branch_addr_i;
    logic                  trap_req_i;
    logic [ADDR_W-1:0]     trap_addr_i;
    logic [NUM_STAGES-1:0] stall_o;
    logic [NUM_STAGES-1:0] flush_o;
    logic                  redirect_o;
    logic [ADDR_W-1:0]     redirect_addr_o;
    logic                  stall_timeout_o;

    modport master (
        output stallreq_i, branch_flag_i, branch_addr_i, trap_req_i, trap_addr_i,
        input  stall_o, flush_o, redirect_o, redirect_addr_o, stall_timeout_o
    );

    modport slave (
        input  stallreq_i, branch_flag_i, branch_addr_i, trap_req_i, trap_addr_i,
        output stall_o, flush_o, redirect_o, redirect_addr_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, redirect flush sequencer and stall watchdog
module pipe_ctrl #(
    parameter int ADDR_W        = 32,
    parameter int NUM_STAGES    = 5,
    parameter int BR_STAGE      = 2,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int WD_W  = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_MAX     = WD_W'(STALL_TIMEOUT);
    localparam logic [NUM_STAGES-1:0] BR_MASK =
        {{(NUM_STAGES-BR_STAGE){1'b0}}, {BR_STAGE{1'b1}}};

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic [NUM_STAGES-1:0] mask;
    logic                  redirect;
    logic [ADDR_W-1:0]     redirect_addr;
    logic                  timeout;
    logic [NUM_STAGES-1:0] stall_m;
    logic [NUM_STAGES-1:0] flush_m;
    logic                  found;
    logic                  any_stall;

    assign any_stall = |bus.stallreq_i;

    // Every stage at or below the highest requester holds; the stage just past it gets the bubble.
    always_comb begin
        stall_m = '0;
        flush_m = '0;
        found   = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (bus.stallreq_i[i]) found = 1'b1;
            stall_m[i] = found;
        end
        for (int j = 1; j < NUM_STAGES; j++) begin
            flush_m[j] = stall_m[j-1] & ~stall_m[j];
        end
    end

    always_comb begin
        bus.stall_o = '0;
        bus.flush_o = '0;
        if (!rst) begin
            if (state == FLUSH) begin
                bus.flush_o = mask;
            end else begin
                bus.stall_o = stall_m;
                bus.flush_o = flush_m;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            cnt           <= '0;
            mask          <= '0;
            redirect      <= 1'b0;
            redirect_addr <= '0;
            wd_cnt        <= '0;
            timeout       <= 1'b0;
        end else begin
            redirect <= 1'b0;
            // A trap restarts the sequence even mid-flush; branches only start one from RUN.
            if (bus.trap_req_i || (state == RUN && bus.branch_flag_i)) begin
                state    <= FLUSH;
                cnt      <= CNT_RELOAD;
                redirect <= 1'b1;
                if (bus.trap_req_i) begin
                    mask          <= '1;
                    redirect_addr <= bus.trap_addr_i;
                end else begin
                    mask          <= BR_MASK;
                    redirect_addr <= bus.branch_addr_i;
                end
            end else if (state == FLUSH) begin
                if (cnt == '0) state <= RUN;
                else           cnt   <= cnt - CNT_W'(1);
            end

            if (STALL_TIMEOUT == 0) begin
                wd_cnt <= '0;
            end else if (state == RUN && any_stall) begin
                if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_cnt == WD_MAX - WD_W'(1)) timeout <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign bus.redirect_o      = redirect;
    assign bus.redirect_addr_o = redirect_addr;
    assign bus.stall_timeout_o = timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and random checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
    localparam int AW = 32;
    localparam int NS = 5;
    localparam int BR = 2;
    localparam int FC = 2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_W(AW), .NUM_STAGES(NS)) bus ();

    pipe_ctrl #(
        .ADDR_W(AW), .NUM_STAGES(NS), .BR_STAGE(BR),
        .FLUSH_CYCLES(FC), .STALL_TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: remaining flush cycles (0 = running), stall streak length.
    int          m_left;
    logic [4:0]  m_mask;
    logic        m_redir;
    logic [31:0] m_addr;
    int          m_run;
    logic        m_to;

    logic [4:0]  obs_stall, obs_flush;
    logic        obs_redir, obs_to;
    logic [31:0] obs_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_mask = '0; m_redir = 1'b0; m_addr = '0; m_run = 0; m_to = 1'b0;
    endtask

    task automatic step(input logic r, input logic [4:0] req, input logic br,
                        input logic [31:0] ba, input logic tr, input logic [31:0] ta);
        logic [4:0] e_stall, e_flush;
        int k;
        logic in_run;
        rst = r;
        bus.stallreq_i = req; bus.branch_flag_i = br; bus.branch_addr_i = ba;
        bus.trap_req_i = tr; bus.trap_addr_i = ta;
        @(negedge clk);
        e_stall = '0; e_flush = '0;
        if (!r) begin
            if (m_left > 0) begin
                e_flush = m_mask;
            end else if (req != 0) begin
                k = $clog2(int'(req) + 1) - 1;
                e_stall = 5'((1 << (k + 1)) - 1);
                e_flush = (k + 1 < NS) ? 5'(1 << (k + 1)) : 5'd0;
            end
        end
        obs_stall = bus.stall_o; obs_flush = bus.flush_o; obs_redir = bus.redirect_o;
        obs_addr = bus.redirect_addr_o; obs_to = bus.stall_timeout_o;
        check("stall_o", 32'(obs_stall), 32'(e_stall));
        check("flush_o", 32'(obs_flush), 32'(e_flush));
        check("redirect_o", 32'(obs_redir), 32'(m_redir));
        check("redirect_addr_o", obs_addr, m_addr);
        check("stall_timeout_o", 32'(obs_to), 32'(m_to));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            in_run = (m_left == 0);
            if (in_run && req != 0) begin
                if (m_run < 1000) m_run++;
                if (TO != 0 && m_run >= TO) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
            if (tr || (in_run && br)) begin
                m_left = FC; m_redir = 1'b1;
                m_mask = tr ? 5'b11111 : 5'((1 << BR) - 1);
                m_addr = tr ? ta : ba;
            end else begin
                m_redir = 1'b0;
                if (!in_run) m_left--;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] req);
        step(1'b0, req, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.stallreq_i = '0; bus.branch_flag_i = 1'b0; bus.branch_addr_i = '0;
        bus.trap_req_i = 1'b0; bus.trap_addr_i = '0;
        @(posedge clk);
        model_reset();
        #1;

        // Reset held with all inputs high
        repeat (3) step(1'b1, 5'h1f, 1'b1, 32'hffff_ffff, 1'b1, 32'hffff_ffff);
        check("rst_stall", 32'(obs_stall), 32'h0);
        check("rst_flush", 32'(obs_flush), 32'h0);
        check("rst_redir", 32'(obs_redir), 32'h0);
        idle(5'b0);
        check("post_rst_addr", obs_addr, 32'h0);

        // Stall merge
        idle(5'b00100);
        check("merge_k2_stall", 32'(obs_stall), 32'h07);
        check("merge_k2_flush", 32'(obs_flush), 32'h08);
        idle(5'b0);
        idle(5'b10000);
        check("merge_k4_stall", 32'(obs_stall), 32'h1f);
        check("merge_k4_flush", 32'(obs_flush), 32'h00);
        idle(5'b0);

        // Branch flush
        step(1'b0, 5'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        idle(5'b0);
        check("br_redir", 32'(obs_redir), 32'h1);
        check("br_addr", obs_addr, 32'h100);
        check("br_flush1", 32'(obs_flush), 32'h03);
        idle(5'b00100);
        check("br_flush2", 32'(obs_flush), 32'h03);
        check("br_stall_masked", 32'(obs_stall), 32'h0);
        check("br_redir2", 32'(obs_redir), 32'h0);
        idle(5'b0);
        check("br_done_flush", 32'(obs_flush), 32'h0);

        // Trap preempting a branch flush
        step(1'b0, 5'b0, 1'b1, 32'h140, 1'b0, 32'h0);
        step(1'b0, 5'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        idle(5'b0);
        check("trap_redir", 32'(obs_redir), 32'h1);
        check("trap_addr", obs_addr, 32'h80);
        check("trap_flush", 32'(obs_flush), 32'h1f);
        idle(5'b0);
        check("trap_flush2", 32'(obs_flush), 32'h1f);
        idle(5'b0);
        step(1'b0, 5'b0, 1'b1, 32'h200, 1'b1, 32'h300);
        idle(5'b0);
        check("same_cycle_addr", obs_addr, 32'h300);
        check("same_cycle_flush", 32'(obs_flush), 32'h1f);
        idle(5'b0);
        idle(5'b0);

        // Reset on the first flush cycle
        step(1'b0, 5'b0, 1'b1, 32'h400, 1'b0, 32'h0);
        step(1'b1, 5'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(5'b0);
        check("rst_flush_redir", 32'(obs_redir), 32'h0);
        check("rst_flush_flush", 32'(obs_flush), 32'h0);

        // Watchdog
        repeat (3) idle(5'b00010);
        idle(5'b0);
        repeat (3) idle(5'b00010);
        idle(5'b0);
        check("wd_no_fire", 32'(obs_to), 32'h0);
        repeat (4) idle(5'b00010);
        check("wd_before", 32'(obs_to), 32'h0);
        idle(5'b0);
        check("wd_fired", 32'(obs_to), 32'h1);
        idle(5'b0);
        check("wd_sticky", 32'(obs_to), 32'h1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom),
                 ($urandom_range(0, 5) == 0), $urandom,
                 ($urandom_range(0, 11) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
